// File: rtl/ram_arb_pkg.sv
// Shared opcodes, FSM states and owner encoding for the two-port RAM command arbiter.
// Pure declarations: no latency, no flow control.
package ram_arb_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RWAIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: pick is combinational, pointer flips away from the winner on advance.
// Zero-latency pick; a lone requester always wins regardless of the pointer.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_a_i,
  input  logic   req_b_i,
  input  logic   advance_i,
  output owner_e pick_o
);

  owner_e ptr_q;

  always_comb begin
    pick_o = ptr_q;
    if (req_a_i && !req_b_i) pick_o = OWN_A;
    else if (req_b_i && !req_a_i) pick_o = OWN_B;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= OWN_A;
    end else if (advance_i) begin
      ptr_q <= (pick_o == OWN_A) ? OWN_B : OWN_A;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one command-word RAM between requesters A/B; write done at gnt+3, read at gnt+3+RD_LATENCY.
// Grants only from IDLE (requesters wait on gnt); RAM_ARB_ADDR_SKIP_EN drops repeated ADDR words.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [ADDR_W-1:0] a_wdata_i,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [ADDR_W-1:0] b_wdata_i,
  output logic              a_gnt_o,
  output logic              b_gnt_o,
  output logic              a_done_o,
  output logic              b_done_o,
  output logic [ADDR_W-1:0] a_rdata_o,
  output logic [ADDR_W-1:0] b_rdata_o,
  output logic [ADDR_W+1:0] ram_din_o,
  output logic              ram_rx_valid_o,
  input  logic [ADDR_W-1:0] ram_dout_i
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            pick;
  logic              we_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W+1:0] din_q;
  logic              vld_q;
  logic              a_done_q, b_done_q;
  logic [ADDR_W-1:0] a_rdata_q, b_rdata_q;

  logic              grant;
  logic              skip;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_wdata;

  function automatic logic [ADDR_W+1:0] data_word(input logic we, input logic [ADDR_W-1:0] wd);
    return we ? {OP_WR_DATA, wd} : {OP_RD_DATA, {ADDR_W{1'b0}}};
  endfunction

  ram_arb_rr u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_a_i  (a_req_i),
    .req_b_i  (b_req_i),
    .advance_i(grant),
    .pick_o   (pick)
  );

  // gnt is combinational so the request is captured in the very cycle it is accepted
  assign grant     = (state_q == ST_IDLE) && (a_req_i || b_req_i) && !rst_i;
  assign a_gnt_o   = grant && (pick == OWN_A);
  assign b_gnt_o   = grant && (pick == OWN_B);
  assign sel_we    = (pick == OWN_A) ? a_we_i    : b_we_i;
  assign sel_addr  = (pick == OWN_A) ? a_addr_i  : b_addr_i;
  assign sel_wdata = (pick == OWN_A) ? a_wdata_i : b_wdata_i;

`ifdef RAM_ARB_ADDR_SKIP_EN
  logic              wr_trk_vld_q, rd_trk_vld_q;
  logic [ADDR_W-1:0] wr_trk_q, rd_trk_q;

  assign skip = sel_we ? (wr_trk_vld_q && (wr_trk_q == sel_addr))
                       : (rd_trk_vld_q && (rd_trk_q == sel_addr));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_trk_vld_q <= 1'b0;
      rd_trk_vld_q <= 1'b0;
      wr_trk_q     <= '0;
      rd_trk_q     <= '0;
    end else if (grant && !skip) begin
      if (sel_we) begin
        wr_trk_vld_q <= 1'b1;
        wr_trk_q     <= sel_addr;
      end else begin
        rd_trk_vld_q <= 1'b1;
        rd_trk_q     <= sel_addr;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      vld_q     <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= pick;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
            vld_q   <= 1'b1;
            if (skip) begin
              din_q   <= data_word(sel_we, sel_wdata);
              state_q <= ST_DATA;
            end else begin
              din_q   <= {(sel_we ? OP_WR_ADDR : OP_RD_ADDR), sel_addr};
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          din_q   <= data_word(we_q, wdata_q);
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          vld_q <= 1'b0;
          if (we_q) begin
            a_done_q <= (owner_q == OWN_A);
            b_done_q <= (owner_q == OWN_B);
            state_q  <= ST_DONE;
          end else begin
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
            state_q <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_A) a_rdata_q <= ram_dout_i;
            else                  b_rdata_q <= ram_dout_i;
            a_done_q <= (owner_q == OWN_A);
            b_done_q <= (owner_q == OWN_B);
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_done_o       = a_done_q;
  assign b_done_o       = b_done_q;
  assign a_rdata_o      = a_rdata_q;
  assign b_rdata_o      = b_rdata_q;
  assign ram_din_o      = din_q;
  assign ram_rx_valid_o = vld_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: grants push expected RAM words and completions; one monitor pops and compares.
// Includes a behavioural command-word RAM with one cycle of read latency.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic          a_gnt, b_gnt, a_done, b_done, rx_valid;
  logic [AW-1:0] a_rdata, b_rdata, ram_dout;
  logic [AW+1:0] din;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .RD_LATENCY(RL)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt), .b_gnt_o(b_gnt), .a_done_o(a_done), .b_done_o(b_done),
    .a_rdata_o(a_rdata), .b_rdata_o(b_rdata),
    .ram_din_o(din), .ram_rx_valid_o(rx_valid), .ram_dout_i(ram_dout)
  );

  // behavioural RAM
  logic [AW-1:0] mem [256];
  logic [AW-1:0] ram_waddr = 0, ram_raddr = 0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (rx_valid) begin
      case (din[AW+1:AW])
        2'b00: ram_waddr <= din[AW-1:0];
        2'b01: mem[ram_waddr] <= din[AW-1:0];
        2'b10: ram_raddr <= din[AW-1:0];
        default: ram_dout <= mem[ram_raddr];
      endcase
    end
  end

  typedef struct {
    bit            side;
    bit            we;
    logic [AW-1:0] rd;
    int            cyc;
  } done_t;

  logic [AW+1:0] wq[$];
  done_t         dq[$];
  bit            ord[$];

  int errors = 0, checks = 0;
  int cyc = 0;
  int last_done_exp = -1;
  bit a_exp_skip = 0, b_exp_skip = 0;
  logic [AW-1:0] a_exp_rd = 0, b_exp_rd = 0;
  logic [AW-1:0] exp_rdata_a = 0, exp_rdata_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rx_valid) begin
      if (wq.size() == 0) chk("ram_word_unexpected", {22'd0, din}, 32'hFFFF_FFFF);
      else chk("ram_word", {22'd0, din}, {22'd0, wq.pop_front()});
    end
    if (a_gnt || b_gnt) begin
      bit            s, we, sk;
      logic [AW-1:0] ad, wd, rd;
      int            lat;
      done_t         e;
      chk("single_gnt", {31'd0, a_gnt & b_gnt}, 32'd0);
      chk("gnt_only_idle", {31'd0, cyc > last_done_exp}, 32'd1);
      s  = b_gnt;
      we = s ? b_we : a_we;
      ad = s ? b_addr : a_addr;
      wd = s ? b_wdata : a_wdata;
      sk = s ? b_exp_skip : a_exp_skip;
      rd = s ? b_exp_rd : a_exp_rd;
      if (ord.size() != 0) chk("rr_order", {31'd0, s}, {31'd0, ord.pop_front()});
      if (!sk) wq.push_back({(we ? 2'b00 : 2'b10), ad});
      wq.push_back(we ? {2'b01, wd} : {2'b11, 8'h00});
      lat = (we ? 3 : 3 + RL) - (sk ? 1 : 0);
      e.side = s; e.we = we; e.rd = rd; e.cyc = cyc + lat;
      dq.push_back(e);
      last_done_exp = cyc + lat;
    end
    if (a_done || b_done) begin
      done_t e;
      chk("done_exclusive", {31'd0, a_done & b_done}, 32'd0);
      if (dq.size() == 0) chk("done_unexpected", {31'd0, b_done}, 32'hFFFF_FFFF);
      else begin
        e = dq.pop_front();
        chk("done_side", {31'd0, b_done}, {31'd0, e.side});
        chk("done_cycle", cyc, e.cyc);
        if (!e.we) begin
          if (e.side) exp_rdata_b = e.rd;
          else        exp_rdata_a = e.rd;
        end
      end
      chk("a_rdata", {24'd0, a_rdata}, {24'd0, exp_rdata_a});
      chk("b_rdata", {24'd0, b_rdata}, {24'd0, exp_rdata_b});
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_gnt"},   {30'd0, a_gnt, b_gnt}, 32'd0);
    chk({tag, "_done"},  {30'd0, a_done, b_done}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, a_rdata, b_rdata}, 32'd0);
    chk({tag, "_din"},   {22'd0, din}, 32'd0);
    chk({tag, "_vld"},   {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", wq.size() + dq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_op(input bit side, input bit we, input logic [AW-1:0] addr,
                       input logic [AW-1:0] wd, input bit sk, input logic [AW-1:0] rd);
    int n = 0;
    @(posedge clk); #1;
    if (side) begin
      b_exp_skip = sk; b_exp_rd = rd; b_we = we; b_addr = addr; b_wdata = wd; b_req = 1;
    end else begin
      a_exp_skip = sk; a_exp_rd = rd; a_we = we; a_addr = addr; a_wdata = wd; a_req = 1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(side ? b_gnt : a_gnt) && n < 50);
    chk("gnt_seen", {31'd0, side ? b_gnt : a_gnt}, 32'd1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    drain();
  endtask

  bit skip_on;

  initial begin
`ifdef RAM_ARB_ADDR_SKIP_EN
    skip_on = 1;
`else
    skip_on = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 0;

    // directed write then read-back from the other side
    do_op(0, 1, 8'h12, 8'h5A, 0, 8'h00);
    chk("mem_12", {24'd0, mem[8'h12]}, 32'h5A);
    do_op(1, 0, 8'h12, 8'h00, 0, 8'h5A);

    // contention: both held, grants must alternate A,B,A,B
    begin
      int n = 0, g = 0;
      ord.push_back(0); ord.push_back(1); ord.push_back(0); ord.push_back(1);
      @(posedge clk); #1;
      a_exp_skip = 0; b_exp_skip = 0;
      a_we = 1; a_addr = 8'h20; a_wdata = 8'h11;
      b_we = 1; b_addr = 8'h21; b_wdata = 8'h22;
      a_req = 1; b_req = 1;
      while (g < 4 && n < 80) begin
        @(negedge clk);
        n++;
        if (a_gnt || b_gnt) g++;
      end
      chk("rr_grants", g, 4);
      @(posedge clk); #1;
      a_req = 0; b_req = 0;
      drain();
      chk("rr_order_used", ord.size(), 0);
      chk("mem_21", {24'd0, mem[8'h21]}, 32'h22);
    end

    // reset during the DATA cycle of a read aborts it
    begin
      int n = 0;
      @(posedge clk); #1;
      b_exp_skip = 0; b_exp_rd = 8'h22; b_we = 0; b_addr = 8'h21; b_req = 1;
      do begin
        @(negedge clk);
        n++;
      end while (!b_gnt && n < 50);
      chk("abort_gnt", {31'd0, b_gnt}, 32'd1);
      @(posedge clk); #1;
      b_req = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      dq.delete();
      last_done_exp = cyc;
      exp_rdata_a = 0; exp_rdata_b = 0;
      @(negedge clk);
      check_quiet("abort");
      chk("abort_words", wq.size(), 0);
      @(posedge clk); #1;
      rst = 0;
      repeat (8) @(negedge clk);
    end
    do_op(0, 1, 8'h33, 8'h44, 0, 8'h00);
    chk("mem_33", {24'd0, mem[8'h33]}, 32'h44);

    // repeated address: ADDR word skipped only with the skip feature
    do_op(0, 1, 8'h40, 8'h77, 0, 8'h00);
    do_op(0, 1, 8'h40, 8'h78, skip_on, 8'h00);
    chk("mem_40", {24'd0, mem[8'h40]}, 32'h78);
    do_op(1, 0, 8'h40, 8'h00, 0, 8'h78);
    do_op(1, 0, 8'h40, 8'h00, skip_on, 8'h78);
    chk("a_rdata_final", {24'd0, a_rdata}, 32'h0);
    chk("b_rdata_final", {24'd0, b_rdata}, 32'h78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
